// File: rtl/dmem_rmw_arb_pkg.sv
// Shared types and helpers for the data-memory read-modify-write arbiter.
// Holds the FSM states, the RV32 size codes and the store-lane merge.
package dmem_rmw_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CRD  = 2'd1,
        CMRG = 2'd2,
        ERD  = 2'd3
    } arb_state_t;

    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_HALF  = 3'b001;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_BYTEU = 3'b100;
    localparam logic [2:0] F3_HALFU = 3'b101;

    // Half needs an even offset; any word-or-larger code needs offset 00.
    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] offset);
        return ((func3[1:0] == 2'b01) && offset[0]) || (func3[1] && (offset != 2'b00));
    endfunction

    function automatic logic is_word(input logic [2:0] func3);
        return func3[1];
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] rword,
                                               input logic [31:0] sdata,
                                               input logic [1:0]  offset,
                                               input logic [2:0]  func3);
        logic [31:0] w;
        w = rword;
        case (func3)
            F3_BYTE, F3_BYTEU: w[{offset, 3'b000} +: 8]       = sdata[7:0];
            F3_HALF, F3_HALFU: w[{offset[1], 4'b0000} +: 16]  = sdata[15:0];
            default:           w                              = sdata;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/dmem_rmw_arb_merge.sv
// Combinational store-lane merge: drops right-aligned store data into the
// addressed byte/half lane of a word that was read back from memory.
module dmem_merge
    import dmem_rmw_arb_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [DataWidth-1:0] rword,
    input  logic [DataWidth-1:0] sdata,
    input  logic [1:0]           offset,
    input  logic [2:0]           func3,
    output logic [DataWidth-1:0] merged
);

    // Lanes are defined on the low 32 bits; wider words keep their upper bits.
    if (DataWidth > 32) begin : g_wide
        assign merged = {rword[DataWidth-1:32], merge_word(rword[31:0], sdata[31:0], offset, func3)};
    end else begin : g_word
        assign merged = merge_word(rword, sdata, offset, func3);
    end

endmodule

// File: rtl/dmem_rmw_arb.sv
// Data-memory port shared between the core load/store stage and an external
// loader/debug master, with read-modify-write for sub-word stores.
module dmem_rmw_arb
    import dmem_rmw_arb_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 15,
    parameter int StarveMax = 4
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic                 core_req,
    input  logic                 core_we,
    input  logic [2:0]           core_func3,
    input  logic [DataWidth-1:0] core_addr,
    input  logic [DataWidth-1:0] core_wdata,
    output logic                 core_stall,
    output logic                 core_rvalid,
    output logic [DataWidth-1:0] core_rdata,
    output logic                 core_err,
    input  logic                 ext_req,
    input  logic                 ext_we,
    input  logic [AddrWidth-1:0] ext_addr,
    input  logic [DataWidth-1:0] ext_wdata,
    output logic                 ext_gnt,
    output logic                 ext_rvalid,
    output logic [DataWidth-1:0] ext_rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic [DataWidth-1:0] mem_rdata
);

    localparam int CntWidth = $clog2(StarveMax + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(StarveMax);

    arb_state_t state, state_next;

    logic [CntWidth-1:0]  starve_cnt;
    logic [DataWidth-1:0] merge_q;
    logic [DataWidth-1:0] merged;
    logic [1:0]           offset;
    logic [AddrWidth-1:0] core_waddr;
    logic                 core_misaligned;
    logic                 ext_win;
    logic                 ext_gnt_c;
    logic                 mem_en_c;
    logic                 mem_we_c;
    logic                 err_next;
    logic                 core_rvalid_next;
    logic                 ext_rvalid_next;
    logic                 cnt_inc;
    logic                 cnt_clr;
    logic                 load_merge;
    logic                 unused_core_addr;

    assign offset           = core_addr[1:0];
    assign core_waddr       = core_addr[AddrWidth+1:2];
    assign core_misaligned  = is_misaligned(core_func3, offset);
    assign unused_core_addr = ^core_addr[DataWidth-1:AddrWidth+2];

    // Core has fixed priority until it has been granted StarveMax times in a row over a waiting ext.
    assign ext_win = ext_req && (!core_req || (starve_cnt == CntMax));

    dmem_merge #(
        .DataWidth (DataWidth)
    ) u_merge (
        .rword  (merge_q),
        .sdata  (core_wdata),
        .offset (offset),
        .func3  (core_func3),
        .merged (merged)
    );

    always_comb begin
        state_next       = state;
        core_stall       = 1'b0;
        ext_gnt_c        = 1'b0;
        mem_en_c         = 1'b0;
        mem_we_c         = 1'b0;
        mem_addr         = core_waddr;
        mem_wdata        = core_wdata;
        err_next         = 1'b0;
        core_rvalid_next = 1'b0;
        ext_rvalid_next  = 1'b0;
        cnt_inc          = 1'b0;
        cnt_clr          = 1'b0;
        load_merge       = 1'b0;
        case (state)
            IDLE: begin
                if (ext_win) begin
                    ext_gnt_c  = 1'b1;
                    cnt_clr    = 1'b1;
                    core_stall = core_req;
                    mem_en_c   = 1'b1;
                    mem_we_c   = ext_we;
                    mem_addr   = ext_addr;
                    mem_wdata  = ext_wdata;
                    if (!ext_we) begin
                        state_next = ERD;
                    end
                end else if (core_req) begin
                    cnt_inc = ext_req;
                    if (core_misaligned) begin
                        err_next = 1'b1;
                    end else if (core_we && is_word(core_func3)) begin
                        mem_en_c = 1'b1;
                        mem_we_c = 1'b1;
                    end else begin
                        mem_en_c   = 1'b1;
                        core_stall = 1'b1;
                        state_next = CRD;
                    end
                end
            end
            CRD: begin
                if (core_we) begin
                    load_merge = 1'b1;
                    core_stall = 1'b1;
                    state_next = CMRG;
                end else begin
                    core_rvalid_next = 1'b1;
                    state_next       = IDLE;
                end
            end
            CMRG: begin
                mem_en_c   = 1'b1;
                mem_we_c   = 1'b1;
                mem_wdata  = merged;
                state_next = IDLE;
            end
            ERD: begin
                core_stall      = core_req;
                ext_rvalid_next = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset gates the combinational strobes so an abandoned merge never writes.
    assign ext_gnt = ext_gnt_c && !brq_rst;
    assign mem_en  = mem_en_c && !brq_rst;
    assign mem_we  = mem_we_c && !brq_rst;

    always_ff @(posedge brq_clk or posedge brq_rst) begin
        if (brq_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge brq_clk or posedge brq_rst) begin
        if (brq_rst) begin
            starve_cnt  <= '0;
            core_rvalid <= 1'b0;
            core_err    <= 1'b0;
            ext_rvalid  <= 1'b0;
            core_rdata  <= '0;
            ext_rdata   <= '0;
            merge_q     <= '0;
        end else begin
            core_rvalid <= core_rvalid_next;
            core_err    <= err_next;
            ext_rvalid  <= ext_rvalid_next;
            if (core_rvalid_next) begin
                core_rdata <= mem_rdata;
            end
            if (ext_rvalid_next) begin
                ext_rdata <= mem_rdata;
            end
            if (load_merge) begin
                merge_q <= mem_rdata;
            end
            if (cnt_clr) begin
                starve_cnt <= '0;
            end else if (cnt_inc && (starve_cnt != CntMax)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_rmw_arb.sv
// Self-checking bench for dmem_rmw_arb: directed scenarios plus randomized
// single-master traffic checked against a word-array reference model.
module tb_dmem_rmw_arb;

    logic        brq_clk = 1'b0;
    logic        brq_rst;
    logic        core_req, core_we;
    logic [2:0]  core_func3;
    logic [31:0] core_addr, core_wdata;
    logic        core_stall, core_rvalid, core_err;
    logic [31:0] core_rdata;
    logic        ext_req, ext_we;
    logic [14:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic        mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int testCount = 0;
    int failCount = 0;

    logic [31:0] sram    [64];
    logic [31:0] ref_mem [64];
    int          acc_count = 0;
    int          wr_count  = 0;

    dmem_rmw_arb dut (
        .brq_clk     (brq_clk),
        .brq_rst     (brq_rst),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_func3  (core_func3),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_stall  (core_stall),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .core_err    (core_err),
        .ext_req     (ext_req),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_gnt     (ext_gnt),
        .ext_rvalid  (ext_rvalid),
        .ext_rdata   (ext_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 brq_clk = ~brq_clk;

    // Synchronous single-port RAM: read data appears the cycle after the read.
    always @(posedge brq_clk) begin
        if (mem_en) begin
            acc_count <= acc_count + 1;
            if (mem_we) begin
                sram[mem_addr[5:0]] <= mem_wdata;
                wr_count            <= wr_count + 1;
            end else begin
                mem_rdata <= sram[mem_addr[5:0]];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic preload(input int word, input logic [31:0] value);
        sram[word]    <= value;
        ref_mem[word]  = value;
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic ref_misaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (addr % size_bytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f3,
                                             input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] mask, data;
        int          sh;
        sh   = 8 * int'(addr % 4);
        case (size_bytes(f3))
            1:       begin mask = 32'hFF   << sh; data = (wd & 32'hFF)   << sh; end
            2:       begin mask = 32'hFFFF << sh; data = (wd & 32'hFFFF) << sh; end
            default: begin mask = 32'hFFFF_FFFF; data = wd; end
        endcase
        return (old & ~mask) | (data & mask);
    endfunction

    // Holds a core request until accepted; reports accept latency and the following-cycle pulses.
    task automatic applyCoreAccess(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wd, output int lat, output logic rv,
                                   output logic [31:0] rd, output logic er, output int accs);
        bit done;
        int acc0;
        @(negedge brq_clk);
        acc0 = acc_count;
        core_req = 1'b1; core_we = we; core_func3 = f3; core_addr = addr; core_wdata = wd;
        lat = 0; done = 0;
        while (!done && lat < 10) begin
            #1;
            lat++;
            if (!core_stall) done = 1;
            else @(negedge brq_clk);
        end
        if (!done) checkOutput("core_accept_timeout", 64'd0, 64'd1);
        @(negedge brq_clk);
        core_req = 1'b0;
        #1;
        rv   = core_rvalid;
        rd   = core_rdata;
        er   = core_err;
        accs = acc_count - acc0;
    endtask

    task automatic applyExtAccess(input logic we, input logic [14:0] addr, input logic [31:0] wd,
                                  output int gnt_wait, output int rv_delay, output logic [31:0] rd);
        bit got;
        @(negedge brq_clk);
        ext_req = 1'b1; ext_we = we; ext_addr = addr; ext_wdata = wd;
        gnt_wait = 0; got = 0;
        while (!got && gnt_wait < 10) begin
            #1;
            gnt_wait++;
            if (ext_gnt) got = 1;
            else @(negedge brq_clk);
        end
        if (!got) checkOutput("ext_gnt_timeout", 64'd0, 64'd1);
        @(negedge brq_clk);
        ext_req  = 1'b0;
        rv_delay = 0;
        rd       = '0;
        if (!we) begin
            got = 0;
            while (!got && rv_delay < 5) begin
                #1;
                rv_delay++;
                if (ext_rvalid) begin
                    got = 1;
                    rd  = ext_rdata;
                end else begin
                    @(negedge brq_clk);
                end
            end
            if (!got) checkOutput("ext_rvalid_timeout", 64'd0, 64'd1);
        end
    endtask

    // Randomized one-master-at-a-time traffic checked against the word-array model.
    task automatic applyStimulus(input int n_ops);
        logic [2:0]  f3_tab [5];
        logic [2:0]  f3;
        logic [31:0] addr, wd, rd;
        logic        we, rv, er, mis;
        int          lat, accs, gw, rvd, w, exp_lat, exp_acc;
        f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
        f3_tab[3] = 3'b100; f3_tab[4] = 3'b101;
        for (int i = 0; i < n_ops; i++) begin
            if ($urandom_range(0, 3) != 3) begin
                we   = 1'($urandom_range(0, 1));
                f3   = we ? f3_tab[$urandom_range(0, 2)] : f3_tab[$urandom_range(0, 4)];
                addr = 32'($urandom_range(0, 255));
                wd   = $urandom;
                w    = int'(addr / 4);
                mis  = ref_misaligned(f3, addr);
                applyCoreAccess(we, f3, addr, wd, lat, rv, rd, er, accs);
                if (mis)                      begin exp_lat = 1; exp_acc = 0; end
                else if (!we)                 begin exp_lat = 2; exp_acc = 1; end
                else if (size_bytes(f3) == 4) begin exp_lat = 1; exp_acc = 1; end
                else                          begin exp_lat = 3; exp_acc = 2; end
                checkOutput("rnd_core_latency", 64'(lat), 64'(exp_lat));
                checkOutput("rnd_core_accesses", 64'(accs), 64'(exp_acc));
                checkOutput("rnd_core_err", 64'(er), 64'(mis));
                checkOutput("rnd_core_rvalid", 64'(rv), 64'(!we && !mis));
                if (!we && !mis) checkOutput("rnd_core_rdata", 64'(rd), 64'(ref_mem[w]));
                if (we && !mis) ref_mem[w] = ref_store(ref_mem[w], f3, addr, wd);
            end else begin
                we = 1'($urandom_range(0, 1));
                w  = $urandom_range(0, 63);
                wd = $urandom;
                applyExtAccess(we, 15'(w), wd, gw, rvd, rd);
                checkOutput("rnd_ext_gnt_wait", 64'(gw), 64'd1);
                if (!we) begin
                    checkOutput("rnd_ext_rvalid_delay", 64'(rvd), 64'd2);
                    checkOutput("rnd_ext_rdata", 64'(rd), 64'(ref_mem[w]));
                end else begin
                    ref_mem[w] = wd;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        rv, er;
        int          lat, accs, gw, rvd, gnt_arb, core_grants, wr0;

        brq_rst = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_func3 = 3'b000; core_addr = '0; core_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        for (int i = 0; i < 64; i++) preload(i, $urandom);
        #1;
        checkOutput("reset_outputs", 64'({core_rvalid, core_err, ext_gnt, ext_rvalid, mem_en, mem_we}), 64'd0);
        checkOutput("reset_core_rdata", 64'(core_rdata), 64'd0);
        checkOutput("reset_ext_rdata", 64'(ext_rdata), 64'd0);
        checkOutput("reset_core_stall", 64'(core_stall), 64'd0);
        repeat (2) @(negedge brq_clk);
        brq_rst = 1'b0;

        // sb into lane 2 of word 1
        @(negedge brq_clk);
        preload(1, 32'h1122_3344);
        applyCoreAccess(1'b1, 3'b000, 32'h0000_0006, 32'h0000_00AB, lat, rv, rd, er, accs);
        ref_mem[1] = ref_store(ref_mem[1], 3'b000, 32'h6, 32'hAB);
        checkOutput("sb_latency", 64'(lat), 64'd3);
        @(negedge brq_clk);
        checkOutput("sb_mem_word1", 64'(sram[1]), 64'h11AB_3344);

        // sh into upper half of word 2
        preload(2, 32'h0);
        applyCoreAccess(1'b1, 3'b001, 32'h0000_000A, 32'h0000_BEEF, lat, rv, rd, er, accs);
        ref_mem[2] = ref_store(ref_mem[2], 3'b001, 32'hA, 32'hBEEF);
        checkOutput("sh_latency", 64'(lat), 64'd3);
        @(negedge brq_clk);
        checkOutput("sh_mem_word2", 64'(sram[2]), 64'hBEEF_0000);

        // misaligned lh
        applyCoreAccess(1'b0, 3'b001, 32'h0000_0003, 32'h0, lat, rv, rd, er, accs);
        checkOutput("lh_mis_err", 64'(er), 64'd1);
        checkOutput("lh_mis_no_stall", 64'(lat), 64'd1);
        checkOutput("lh_mis_no_mem", 64'(accs), 64'd0);
        checkOutput("lh_mis_rvalid", 64'(rv), 64'd0);
        @(negedge brq_clk); #1;
        checkOutput("lh_mis_err_one_cycle", 64'(core_err), 64'd0);

        // ext write then read of word 7
        applyExtAccess(1'b1, 15'd7, 32'hDEAD_BEEF, gw, rvd, rd);
        ref_mem[7] = 32'hDEAD_BEEF;
        checkOutput("ext_wr_gnt_wait", 64'(gw), 64'd1);
        applyExtAccess(1'b0, 15'd7, 32'h0, gw, rvd, rd);
        checkOutput("ext_rd_delay", 64'(rvd), 64'd2);
        checkOutput("ext_rd_data", 64'(rd), 64'hDEAD_BEEF);

        // back-to-back core word stores while ext waits
        @(negedge brq_clk);
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 15'd20; ext_wdata = 32'hCAFE_0020;
        core_req = 1'b1; core_we = 1'b1; core_func3 = 3'b010; core_addr = 32'd40; core_wdata = 32'h5A5A_0010;
        gnt_arb = 0; core_grants = 0;
        for (int arb = 1; arb <= 10 && gnt_arb == 0; arb++) begin
            #1;
            if (ext_gnt) begin
                gnt_arb = arb;
                checkOutput("starve_core_stalled", 64'(core_stall), 64'd1);
            end else if (!core_stall) begin
                core_grants++;
            end
            @(negedge brq_clk);
        end
        ext_req = 1'b0;
        #1;
        checkOutput("starve_gnt_arbitration", 64'(gnt_arb), 64'd5);
        checkOutput("starve_core_grants", 64'(core_grants), 64'd4);
        checkOutput("starve_core_resumes", 64'(core_stall), 64'd0);
        @(negedge brq_clk);
        core_req = 1'b0;
        ref_mem[10] = 32'h5A5A_0010;
        ref_mem[20] = 32'hCAFE_0020;

        applyStimulus(200);

        // reset during CMRG of a sh to word 3
        @(negedge brq_clk);
        core_req = 1'b1; core_we = 1'b1; core_func3 = 3'b001; core_addr = 32'h0000_000C; core_wdata = 32'h0000_7777;
        @(negedge brq_clk);
        @(negedge brq_clk);
        #1;
        checkOutput("rst_in_cmrg_precheck", 64'(mem_we), 64'd1);
        wr0 = wr_count;
        brq_rst = 1'b1;
        core_req = 1'b0;
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 15'd5;
        #1;
        checkOutput("rst_cmrg_outputs", 64'({core_rvalid, core_err, ext_gnt, ext_rvalid, mem_en, mem_we}), 64'd0);
        checkOutput("rst_cmrg_core_rdata", 64'(core_rdata), 64'd0);
        checkOutput("rst_cmrg_ext_rdata", 64'(ext_rdata), 64'd0);
        @(negedge brq_clk);
        ext_req = 1'b0;
        @(negedge brq_clk);
        checkOutput("rst_cmrg_no_write", 64'(wr_count - wr0), 64'd0);
        checkOutput("rst_cmrg_word3_intact", 64'(sram[3]), 64'(ref_mem[3]));
        brq_rst = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_func3 = 3'b010; core_addr = 32'h0000_000C;
        #1;
        checkOutput("rst_release_accept_read", 64'({core_stall, mem_en, mem_we}), 64'b110);
        @(negedge brq_clk); #1;
        checkOutput("rst_release_load_done", 64'(core_stall), 64'd0);
        @(negedge brq_clk);
        core_req = 1'b0;
        #1;
        checkOutput("rst_release_rvalid", 64'(core_rvalid), 64'd1);
        checkOutput("rst_release_rdata", 64'(core_rdata), 64'(ref_mem[3]));

        @(negedge brq_clk);
        for (int i = 0; i < 64; i++) checkOutput($sformatf("final_mem_%0d", i), 64'(sram[i]), 64'(ref_mem[i]));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/dmem_rmw_arb.md
DMEM_RMW_ARB -- requirements
Module: dmem_rmw_arb

Interface
REQ-001 The module SHALL have parameter DataWidth, default 32, meaning the data-memory word width.
REQ-002 The module SHALL have parameter AddrWidth, default 15, meaning the data-memory word-address width.
REQ-003 The module SHALL have parameter StarveMax, default 4, meaning the number of consecutive core grants allowed while ext waits.
REQ-004 The ports SHALL be, in order:
- brq_clk  in  1  single clock, rising edge.
- brq_rst  in  1  reset, asynchronous, active-high.
- core_req  in  1  core access request, held until core_stall is low.
- core_we  in  1  1 = store, 0 = load.
- core_func3  in  3  RV32 size code: 000/100 byte, 001/101 half, 010 word.
- core_addr  in  DataWidth  byte address.
- core_wdata  in  DataWidth  store data, right-aligned.
- core_stall  out  1  core must hold its request.
- core_rvalid  out  1  one-cycle pulse; core_rdata is valid.
- core_rdata  out  DataWidth  raw memory word; the load stage extracts the bytes.
- core_err  out  1  one-cycle pulse on a misaligned access.
- ext_req  in  1  external (loader/debug) request.
- ext_we  in  1  external write.
- ext_addr  in  AddrWidth  word address.
- ext_wdata  in  DataWidth  full-word write data.
- ext_gnt  out  1  one-cycle pulse; the request is accepted.
- ext_rvalid  out  1  one-cycle pulse; ext_rdata is valid.
- ext_rdata  out  DataWidth  read word.
- mem_en  out  1  memory cycle enable.
- mem_we  out  1  memory write.
- mem_addr  out  AddrWidth  word address.
- mem_wdata  out  DataWidth  write word.
- mem_rdata  in  DataWidth  read data, valid one cycle after a read cycle (mem_en=1, mem_we=0).

Function
REQ-005 Byte offset SHALL be core_addr[1:0], and the word address SHALL be core_addr[AddrWidth+1:2].
REQ-006 A halfword with offset 01 or 11, or a word with offset other than 00, SHALL be misaligned: pulse core_err for one cycle, make no memory access, and keep core_stall low for that request.
REQ-007 The FSM SHALL have states IDLE, CRD (core read), CMRG (core merge-write) and ERD (ext read return).
REQ-008 In IDLE, if the core wins arbitration with an aligned word store, the block SHALL drive one write cycle that same cycle (mem_wdata = core_wdata), stay in IDLE, and keep core_stall low.
REQ-009 In IDLE, if the core wins with a load or a sub-word store, the block SHALL drive a read cycle, assert core_stall combinationally, and go to CRD.
REQ-010 In CRD for a load, the block SHALL copy mem_rdata to core_rdata, pulse core_rvalid, drop core_stall and return to IDLE; total load latency is 2 cycles.
REQ-011 In CRD for a sub-word store, the block SHALL register mem_rdata, keep core_stall high and go to CMRG.
REQ-012 In CMRG, the block SHALL write the merged word, drop core_stall and return to IDLE; total sub-word store latency is 3 cycles.
REQ-013 The merge SHALL work as follows:
- Byte store: core_wdata[7:0] replaces byte lane offset; other lanes come from the read word.
- Halfword store: core_wdata[15:0] replaces bits [15:0] (offset 00) or [31:16] (offset 10).
REQ-014 In IDLE, if ext wins, the block SHALL pulse ext_gnt.
- Ext write: one write cycle, stay in IDLE.
- Ext read: read cycle, then go to ERD; in ERD, ext_rvalid pulses with ext_rdata = mem_rdata, then return to IDLE.
REQ-015 Arbitration SHALL happen only in IDLE, and an access in progress (CRD, CMRG, ERD) SHALL never be preempted.
REQ-016 The core SHALL have fixed priority, except that a starvation counter counts core grants made while ext_req is high; when it reaches StarveMax, ext SHALL win the next arbitration and the counter SHALL clear.
REQ-017 The starvation counter SHALL also clear on any ext grant, and SHALL saturate (no wrap).
REQ-018 While the block is busy (not IDLE) or ext has won, a pending core_req SHALL see core_stall high.
REQ-019 mem_en SHALL be low in every cycle with no memory access, and mem_wdata/mem_addr are don't-care when mem_en is low.

Reset
REQ-020 Asserting brq_rst SHALL immediately force state IDLE, starvation counter 0, and core_rvalid, core_err, ext_gnt, ext_rvalid, mem_en and mem_we all 0; core_rdata, ext_rdata and the merge register SHALL reset to 0.
REQ-021 Reset during CRD or CMRG SHALL abandon the access with no memory write issued, and on release the block SHALL accept requests in the first cycle.

Structure
REQ-022 A shared package SHALL hold the FSM state enum, the func3 size constants (byte, half, word, and unsigned variants) and a merge function.
REQ-023 One sub-module SHALL exist, dmem_merge (combinational lane merge taking read word, store data, offset and size), reused by the load/store stage.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- sb, core_addr=0x00000006, core_wdata=0xAB, memory word 1 = 0x11223344 -> 3-cycle stall, then memory word 1 = 0x11AB3344.
- sh, core_addr=0x0000000A, core_wdata=0xBEEF, memory word 2 = 0x0 -> memory word 2 = 0xBEEF0000.
- lh, core_addr=0x00000003 -> core_err pulses once, mem_en stays 0, core_stall stays 0.
- Core requests back-to-back with ext_req held high -> ext_gnt on arbitration 5, after 4 core grants.
- Ext write 0xDEADBEEF to word 7 then ext read of word 7 -> ext_rvalid with 0xDEADBEEF 2 cycles after the read grant.
- brq_rst asserted in CMRG -> no write issued, all outputs 0, and a load accepted in the first cycle after release.
